// File: rtl/mul_hilo_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_hilo_unit_pkg
//   Shared definitions for the HI/LO multiply sequencing stage:
//     - op_sel encodings used by both this unit and the ID decoder
//     - FSM state encoding
//     - latency counter width
//     - debug view of the sequencing FSM (state + latency counter)
// ---------------------------------------------------------------------------
package mul_hilo_unit_pkg;

    // Width of the latency counter; covers MUL_LATENCY values 1..15.
    localparam int CNT_W = 4;

    // op_sel encodings. 5..7 are reserved and behave as NOP.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MTHI  = 3'd3,
        OP_MTLO  = 3'd4,
        OP_RSV5  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    // Sequencing FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Observable snapshot of the sequencing FSM. The top drives all of its
    // control decisions from this struct so the state a checker binds to is
    // exactly the state the logic acts on.
    typedef struct packed {
        state_e           state;
        logic [CNT_W-1:0] cnt;
    } fsm_dbg_t;

    // True for the two opcodes that start a multiply.
    function automatic logic is_mul_op(input op_e op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/mul_hilo_unit_mul.sv
// ---------------------------------------------------------------------------
// mul_hilo_unit_mul
//   Combinational 32x32 -> 64 multiplier.
//   Ports:
//     sign_flag  in   1   1: operands are two's complement, 0: unsigned
//     a          in   32  multiplicand
//     b          in   32  multiplier
//     hi         out  32  product bits 63:32
//     lo         out  32  product bits 31:0
//   Both operands are extended to 64 bits according to sign_flag and
//   multiplied modulo 2^64. The low 64 bits of the product of the extended
//   operands equal the exact signed or unsigned 64-bit product, so one
//   multiplier serves both MULT and MULTU.
// ---------------------------------------------------------------------------
module mul_hilo_unit_mul (
    input  logic        sign_flag,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    always_comb begin
        a_ext = {{32{sign_flag & a[31]}}, a};
        b_ext = {{32{sign_flag & b[31]}}, b};
        prod  = a_ext * b_ext;
    end

    assign hi = prod[63:32];
    assign lo = prod[31:0];

endmodule

// File: rtl/mul_hilo_unit.sv
// ---------------------------------------------------------------------------
// mul_hilo_unit
//   Sequencing and result stage around the combinational multiplier.
//   Accepts MULT/MULTU/MTHI/MTLO from EX, holds latched operands stable for
//   MUL_LATENCY cycles, then commits the 64-bit product into HI/LO.
//
//   Parameters:
//     MUL_LATENCY  cycles from accept edge to HI/LO update edge (1..15)
//
//   Ports:
//     clk       in   1   system clock, posedge
//     rst       in   1   synchronous active-high reset, highest priority
//     op_valid  in   1   request present this cycle
//     op_sel    in   3   NOP/MULT/MULTU/MTHI/MTLO, 5..7 reserved
//     op_a      in   32  multiplicand / MTHI-MTLO write data
//     op_b      in   32  multiplier
//     op_ready  out  1   request accepted at posedge when op_valid & op_ready
//     busy      out  1   multiply in flight, EX stalls MFHI/MFLO while high
//     done      out  1   one-cycle pulse after HI/LO take a product
//     hi_out    out  32  architectural HI
//     lo_out    out  32  architectural LO
//
//   Handshake: a request transfers on a posedge where op_valid and op_ready
//   are both high. op_ready depends only on the FSM state (never on
//   op_valid); requests seen while op_ready is low are dropped, not queued,
//   so EX must hold them until it sees op_ready.
// ---------------------------------------------------------------------------
module mul_hilo_unit
    import mul_hilo_unit_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    // Counter load value: the accept edge is cycle 0, the commit happens on
    // the edge where the counter has run down to zero.
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MUL_LATENCY - 1);

    // FSM state and counter
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    fsm_dbg_t         dbg;

    // Latched operands feeding the multiplier
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        sign_q;

    // Architectural registers and the done pulse
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    // Multiplier result
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;

    // Decoded request
    op_e  op_dec;
    logic accept;
    logic start_mul;
    logic commit;

    assign dbg = '{state: state_q, cnt: cnt_q};

    assign op_dec    = op_e'(op_sel);
    assign accept    = op_valid & op_ready;
    assign start_mul = accept & is_mul_op(op_dec);
    // Final BUSY edge: product has been stable for MUL_LATENCY cycles.
    assign commit    = (dbg.state == ST_BUSY) && (dbg.cnt == '0);

    // ------------------------------------------------------------------
    // Multiplier: sees only the latched operands, so EX is free to change
    // op_a/op_b once the request has been accepted.
    // ------------------------------------------------------------------
    mul_hilo_unit_mul u_mul (
        .sign_flag (sign_q),
        .a         (opa_q),
        .b         (opb_q),
        .hi        (mul_hi),
        .lo        (mul_lo)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = dbg.state;
        case (dbg.state)
            ST_IDLE: begin
                if (start_mul) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (commit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (Moore, from state only)
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        op_ready = 1'b1;
        if (dbg.state == ST_BUSY) begin
            busy     = 1'b1;
            op_ready = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Latency counter and operand latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            if (start_mul) begin
                cnt_q  <= LAT_M1;
                opa_q  <= op_a;
                opb_q  <= op_b;
                sign_q <= (op_dec == OP_MULT);
            end else if ((dbg.state == ST_BUSY) && (dbg.cnt != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // HI/LO registers and done pulse.
    // MTHI/MTLO can only be accepted in IDLE, so they never collide with a
    // product commit on the same edge. HI/LO are untouched while BUSY until
    // the commit edge writes both together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (commit) begin
                hi_q   <= mul_hi;
                lo_q   <= mul_lo;
                done_q <= 1'b1;
            end else if (accept && (op_dec == OP_MTHI)) begin
                hi_q <= op_a;
            end else if (accept && (op_dec == OP_MTLO)) begin
                lo_q <= op_a;
            end
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_hilo_unit
//   Directed bench for mul_hilo_unit. dut0 runs at MUL_LATENCY=4, dut1 at
//   MUL_LATENCY=1. Inputs are driven right after a posedge or at a negedge,
//   outputs are sampled at negedges.
// ---------------------------------------------------------------------------
module tb_mul_hilo_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0 (latency 4)
    logic        op_valid = 1'b0;
    logic [2:0]  op_sel   = 3'd0;
    logic [31:0] op_a     = '0;
    logic [31:0] op_b     = '0;
    logic        op_ready, busy, done;
    logic [31:0] hi_out, lo_out;

    // dut1 (latency 1)
    logic        op_valid1 = 1'b0;
    logic [2:0]  op_sel1   = 3'd0;
    logic [31:0] op_a1     = '0;
    logic [31:0] op_b1     = '0;
    logic        op_ready1, busy1, done1;
    logic [31:0] hi_out1, lo_out1;

    mul_hilo_unit #(.MUL_LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_sel(op_sel),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .busy(busy),
        .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    mul_hilo_unit #(.MUL_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid1), .op_sel(op_sel1),
        .op_a(op_a1), .op_b(op_b1), .op_ready(op_ready1), .busy(busy1),
        .done(done1), .hi_out(hi_out1), .lo_out(lo_out1)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    // ---------------- driver tasks ----------------
    // Present one request to dut0 for exactly one accept edge, then follow it
    // to completion and compare HI/LO against the queued expectation.
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] hi0, lo0;
        int          bc;
        bit          held;
        bit          is_mul;
        logic [63:0] exp;
        exp_q.push_back({v.exp_hi, v.exp_lo});
        is_mul = (v.sel == 3'd1) || (v.sel == 3'd2);
        @(negedge clk);
        hi0 = hi_out;
        lo0 = lo_out;
        check($sformatf("v%0d_ready", idx), 64'(op_ready), 64'd1);
        op_valid = 1'b1; op_sel = v.sel; op_a = v.a; op_b = v.b;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op_sel = 3'd0;
        bc   = 0;
        held = 1'b1;
        if (is_mul) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!busy) break;
                bc++;
                if (hi_out !== hi0 || lo_out !== lo0) held = 1'b0;
            end
            check($sformatf("v%0d_busy_cycles", idx), 64'(bc), 64'd4);
            check($sformatf("v%0d_hold", idx), 64'(held), 64'd1);
            check($sformatf("v%0d_done", idx), 64'(done), 64'd1);
        end else begin
            @(negedge clk);
            check($sformatf("v%0d_no_busy", idx), 64'(busy), 64'd0);
            check($sformatf("v%0d_no_done", idx), 64'(done), 64'd0);
        end
        exp = exp_q.pop_front();
        check($sformatf("v%0d_hilo", idx), {hi_out, lo_out}, exp);
        if (is_mul) begin
            @(negedge clk);
            check($sformatf("v%0d_done_clear", idx), 64'(done), 64'd0);
        end
    endtask

    // Wait (bounded) for dut0 done; returns 1 if seen, sampled at negedge.
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Single-edge issue on dut0 without follow-up.
    task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1; op_sel = sel; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op_sel = 3'd0;
    endtask

    // ---------------- main test ----------------
    initial begin
        bit seen;
        int done_cnt;

        vecs[0]  = '{3'd1, 32'h0000000F, 32'h00000007, 32'h00000000, 32'h00000069};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[4]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[5]  = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[6]  = '{3'd3, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 32'h80000000};
        vecs[7]  = '{3'd4, 32'h0000BEEF, 32'h12345678, 32'hA5A5A5A5, 32'h0000BEEF};
        vecs[8]  = '{3'd0, 32'h11111111, 32'h22222222, 32'hA5A5A5A5, 32'h0000BEEF};
        vecs[9]  = '{3'd7, 32'h33333333, 32'h44444444, 32'hA5A5A5A5, 32'h0000BEEF};
        vecs[10] = '{3'd1, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000};

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_hilo", {hi_out, lo_out}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(op_ready), 64'd1);
        check("rst_hilo_l1", {hi_out1, lo_out1}, 64'd0);

        // latency 1, back-to-back MULT 2x2 then 3x3 (request held while busy)
        @(negedge clk);
        op_valid1 = 1'b1; op_sel1 = 3'd1; op_a1 = 32'd2; op_b1 = 32'd2;
        @(negedge clk);                       // after accept edge k
        check("l1_busy_k", 64'(busy1), 64'd1);
        check("l1_ready_k", 64'(op_ready1), 64'd0);
        op_a1 = 32'd3; op_b1 = 32'd3;
        @(negedge clk);                       // after edge k+1
        check("l1_lo_k1", 64'(lo_out1), 64'd4);
        check("l1_done_k1", 64'(done1), 64'd1);
        check("l1_busy_k1", 64'(busy1), 64'd0);
        @(negedge clk);                       // after edge k+2: second accepted
        check("l1_busy_k2", 64'(busy1), 64'd1);
        check("l1_done_k2", 64'(done1), 64'd0);
        check("l1_lo_k2", 64'(lo_out1), 64'd4);
        op_valid1 = 1'b0; op_sel1 = 3'd0;
        @(negedge clk);                       // after edge k+3
        check("l1_lo_k3", 64'(lo_out1), 64'd9);
        check("l1_done_k3", 64'(done1), 64'd1);

        // table-driven vectors on dut0
        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // MTHI while busy is refused, then accepted after done
        issue(3'd1, 32'd2, 32'd3);
        @(negedge clk);
        op_valid = 1'b1; op_sel = 3'd3; op_a = 32'h12345678;
        check("mthi_busy_ready", 64'(op_ready), 64'd0);
        wait_done(seen);
        op_valid = 1'b0; op_sel = 3'd0;
        check("mthi_busy_seen_done", 64'(seen), 64'd1);
        check("mthi_busy_hilo", {hi_out, lo_out}, 64'd6);
        issue(3'd3, 32'h12345678, 32'd0);
        @(negedge clk);
        check("mthi_after_hi", 64'(hi_out), 64'h12345678);
        check("mthi_after_busy", 64'(busy), 64'd0);

        // operand changes after accept do not leak into the product
        issue(3'd1, 32'd3, 32'd5);
        op_a = 32'hDEADBEEF; op_b = 32'hDEADBEEF;
        wait_done(seen);
        check("opnd_hold_seen_done", 64'(seen), 64'd1);
        check("opnd_hold_hilo", {hi_out, lo_out}, 64'h0000_0000_0000_000F);

        // reset in flight discards the product and suppresses done
        issue(3'd3, 32'h12345678, 32'd0);     // make HI non-zero first
        issue(3'd1, 32'h00010000, 32'h00010000);
        @(posedge clk);                        // edge k+1
        #1 rst = 1'b1;
        @(posedge clk);                        // edge k+2 resets
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_fly_hilo", {hi_out, lo_out}, 64'd0);
        check("rst_fly_busy", 64'(busy), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_fly_no_done", 64'(done_cnt), 64'd0);
        issue(3'd2, 32'd2, 32'd3);
        wait_done(seen);
        check("rst_fly_next_seen_done", 64'(seen), 64'd1);
        check("rst_fly_next_hilo", {hi_out, lo_out}, 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
